// File: rtl/fp_pkg.sv
// Shared constants and the stage-1 bundle for the FP multiply
// round/pack pipeline.
package fp_pkg;

    localparam logic [1:0] CLASS_NORMAL = 2'b00;
    localparam logic [1:0] CLASS_ZERO   = 2'b01;
    localparam logic [1:0] CLASS_INF    = 2'b10;
    localparam logic [1:0] CLASS_NAN    = 2'b11;

    localparam logic [31:0]       QNAN    = 32'h7FC0_0000;
    localparam int                BIAS    = 127;
    localparam logic signed [9:0] EXP_MAX = 10'sd255;

    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [22:0] mant;
        logic        guard;
        logic        sticky;
        logic [1:0]  cls;
    } norm_t;

endpackage

// File: rtl/fp_round_rne.sv
// Stage-2 combinational round-to-nearest-even and IEEE single pack,
// including overflow/flush handling and special-class outputs.
module fp_round_rne
    import fp_pkg::*;
(
    input  logic        sign,
    input  logic [9:0]  exp,
    input  logic [22:0] mant,
    input  logic        guard,
    input  logic        sticky,
    input  logic [1:0]  cls,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    logic              inc;
    logic [23:0]       mant_sum;
    logic signed [9:0] exp_rnd;

    always_comb begin
        inc      = guard & (sticky | mant[0]);
        mant_sum = {1'b0, mant} + {23'd0, inc};
        // A carry out of the fraction leaves it all-zero; only exp moves.
        exp_rnd  = $signed(exp + {9'd0, mant_sum[23]});
        result   = {sign, 31'h0};
        flags    = 4'b0000;
        unique case (cls)
            CLASS_NAN: begin
                result = QNAN;
                flags  = 4'b1000;
            end
            CLASS_INF:  result = {sign, 8'hFF, 23'h0};
            CLASS_ZERO: result = {sign, 31'h0};
            CLASS_NORMAL: begin
                if (exp_rnd >= EXP_MAX) begin
                    result = {sign, 8'hFF, 23'h0};
                    flags  = 4'b0101;
                end else if (exp_rnd <= 10'sd0) begin
                    result = {sign, 31'h0};
                    flags  = 4'b0011;
                end else begin
                    result = {sign, exp_rnd[7:0], mant_sum[22:0]};
                    flags  = {3'b000, guard | sticky};
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mul_round_pack.sv
// Two-stage normalize / round-pack back end of a single-precision
// multiplier with valid/ready on both sides and sticky exception flags.
module fp_mul_round_pack
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [47:0] in_prod,
    input  logic [1:0]  in_class,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags,
    output logic [3:0]  sticky_flags,
    input  logic        flags_clr
);

    norm_t       s1_d;
    norm_t       s1_q;
    logic        s1_valid;
    logic        s2_valid;
    logic        s1_advance;
    logic [31:0] rnd_result;
    logic [3:0]  rnd_flags;

    assign s1_advance = !s2_valid | out_ready;
    assign in_ready   = !s1_valid | s1_advance;
    assign out_valid  = s2_valid;

    always_comb begin
        s1_d.sign = in_sign;
        s1_d.cls  = in_class;
        if (in_prod[47]) begin
            s1_d.mant   = in_prod[46:24];
            s1_d.guard  = in_prod[23];
            s1_d.sticky = |in_prod[22:0];
            s1_d.exp    = in_exp + 10'd1;
        end else begin
            s1_d.mant   = in_prod[45:23];
            s1_d.guard  = in_prod[22];
            s1_d.sticky = |in_prod[21:0];
            s1_d.exp    = in_exp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            s1_q     <= s1_d;
        end
    end

    fp_round_rne u_round (
        .sign   (s1_q.sign),
        .exp    (s1_q.exp),
        .mant   (s1_q.mant),
        .guard  (s1_q.guard),
        .sticky (s1_q.sticky),
        .cls    (s1_q.cls),
        .result (rnd_result),
        .flags  (rnd_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            out_result <= 32'h0;
            out_flags  <= 4'h0;
        end else if (s1_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= rnd_result;
                out_flags  <= rnd_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_flags <= 4'h0;
        end else if (flags_clr) begin
            sticky_flags <= 4'h0;
        end else if (s2_valid && out_ready) begin
            sticky_flags <= sticky_flags | out_flags;
        end
    end

endmodule

// File: doc/fp_mul_round_pack.md
FP_MUL_ROUND_PACK -- requirements
Module: fp_mul_round_pack

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising-edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: in_valid  in  1  upstream product word valid.
REQ-004 SHALL have: in_ready  out  1  block accepts word this cycle.
REQ-005 SHALL have: in_sign  in  1  product sign (XOR of operand signs).
REQ-006 SHALL have: in_exp  in  10  signed two's-complement biased sum e1+e2-127.
REQ-007 SHALL have: in_prod  in  48  unsigned 24x24 mantissa product, hidden bits included.
REQ-008 SHALL have: in_class  in  2  00 normal, 01 zero, 10 inf, 11 nan.
REQ-009 SHALL have: out_valid  out  1  / out_ready  in  1  downstream handshake.
REQ-010 SHALL have: out_result  out  32  IEEE-754 single result.
REQ-011 SHALL have: out_flags  out  4  {invalid, overflow, underflow, inexact} for out_result.
REQ-012 SHALL have: sticky_flags  out  4  accumulated out_flags; flags_clr  in  1  clears them.

Function
REQ-013 Transfer SHALL occur on valid&ready, both interfaces.
REQ-014 Pipeline SHALL be 2 register stages; latency in-transfer to out_valid = 2 cycles; throughput 1 word/cycle when out_ready=1.
REQ-015 in_ready SHALL = !s1_valid | s1_advance, where s1_advance = !s2_valid | out_ready; no combinational in_valid->in_ready path.
REQ-016 While out_valid&!out_ready, out_result/out_flags SHALL hold stable; no word dropped or duplicated.
REQ-017 Stage 1 (normalize): if in_prod[47]: mant=in_prod[46:24], guard=in_prod[23], sticky=|in_prod[22:0], exp=in_exp+1; else mant=in_prod[45:23], guard=in_prod[22], sticky=|in_prod[21:0], exp=in_exp.
REQ-018 Stage 2 (round, nearest-even): inc = guard&(sticky|mant[0]); mant+inc carry-out SHALL zero mant and add 1 to exp; inexact = guard|sticky.
REQ-019 Rounded exp>=255 SHALL give {sign,8'hFF,23'h0}, overflow=1, inexact=1.
REQ-020 Rounded exp<=0 SHALL flush to {sign,31'h0}, underflow=1, inexact=1; no subnormals produced.
REQ-021 in_class nan SHALL give 32'h7FC00000, invalid=1; inf SHALL give {sign,8'hFF,23'h0}; zero SHALL give {sign,31'h0}; all other flags 0 for special classes.
REQ-022 Exp arithmetic SHALL be 10-bit signed; no wrap for in_exp in -127..383.
REQ-023 sticky_flags SHALL OR in out_flags on each output transfer; flags_clr has priority over a same-cycle OR-in (result = 0 that cycle, next transfer accumulates normally).

Reset
REQ-024 rst_n low SHALL asynchronously clear s1_valid, s2_valid, out_valid, sticky_flags; out_result, out_flags reset to 0.
REQ-025 Reset mid-operation SHALL discard all in-flight words; in_ready=1 first cycle after release.

Structure
REQ-026 in_class encodings, quiet-NaN constant 32'h7FC00000, bias 127, exp max 255 SHALL live in shared package fp_pkg.
REQ-027 One sub-module fp_round_rne (combinational stage-2 round/pack) is natural; stage registers and handshake stay in top.

Verification
REQ-028 1.5*1.5: in_exp=127, in_prod=48'h9000_0000_0000, class normal -> out_result=32'h40100000, flags 0, 2 cycles later.
REQ-029 Tie-to-odd: in_exp=127, in_prod=48'h4000_00C0_0000 -> 32'h3F800002, inexact=1; same with lsb even (48'h4000_0040_0000) -> 32'h3F800000, inexact=1.
REQ-030 Overflow: in_exp=254, in_prod=48'h8000_0000_0000 -> 32'h7F800000, overflow=1; underflow: in_exp=0, in_prod bit46 set -> 32'h00000000, underflow=1.
REQ-031 Backpressure: out_ready=0 for 4 cycles, in_valid=1 with 3 distinct words -> 2 accepted, in_ready=0 after, out_result stable; out_ready=1 -> all 3 emitted in order, back-to-back.
REQ-032 Special + sticky: class nan then normal exact word -> 32'h7FC00000 invalid=1, sticky_flags=4'b1000 retained; flags_clr pulse -> 4'b0000.
REQ-033 Reset with 2 words in flight -> out_valid=0 immediately, no stale output after release.
